// File: rtl/shift_pkg.sv
// Shared types and helpers for the serializer/deserializer family.
package shift_pkg;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } ser_state_t;

  // Number of LANES-wide beats needed to carry one W-bit word.
  function automatic int unsigned beats(input int unsigned w, input int unsigned lanes);
    return (lanes == 0) ? 0 : w / lanes;
  endfunction

  // Counter width for a given beat count; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n_beats);
    return (n_beats > 1) ? $clog2(n_beats) : 1;
  endfunction

endpackage

// File: rtl/piso_serializer_beat_counter.sv
// Beat counter shared by the serializer and deserializer: counts 0..MAX,
// clr wins over inc, and at_max_o flags the final beat of a word.
module beat_counter #(
  parameter int unsigned MAX = 3,
  parameter int unsigned CW  = (MAX > 0) ? $clog2(MAX + 1) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc_i,
  input  logic          clr_i,
  output logic [CW-1:0] count_o,
  output logic          at_max_o
);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  assign at_max_o = (count_q == CW'(MAX));
  assign count_o  = count_q;

  // Next count: clear, wrap at MAX, or step by one.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i) begin
      count_d = at_max_o ? '0 : count_q + CW'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer. A W-bit word leaves as W/LANES beats;
// the next word loads in the same cycle the last beat is taken, so a
// continuous input stream produces gap-free output.
module piso_serializer
  import shift_pkg::*;
#(
  parameter int unsigned W         = 8,
  parameter int unsigned LANES     = 1,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [W-1:0]     in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [LANES-1:0] out_data_o,
  output logic             out_last_o,
  output logic             busy_o
);

  localparam int unsigned BEATS = beats(W, LANES);
  localparam int unsigned CW    = cnt_width(BEATS);

  if (W < 1 || LANES < 1 || (W % LANES) != 0) begin : g_bad_cfg
    $error("piso_serializer: W must be a nonzero multiple of LANES");
  end

  ser_state_t    state_q, state_d;
  logic [W-1:0]  sreg_q, sreg_d;
  logic [CW-1:0] beat_cnt;
  logic          cnt_at_max;
  logic          xfer;
  logic          load;
  logic          cnt_inc;
  logic          cnt_clr;

  assign out_valid_o = (state_q == S_SHIFT);
  assign busy_o      = (state_q == S_SHIFT);
  // Gated by out_valid so a single-beat configuration shows 0 while idle.
  assign out_last_o  = out_valid_o && (beat_cnt == CW'(BEATS - 1));
  assign xfer        = out_valid_o && out_ready_i;
  assign in_ready_o  = !clear_i && ((state_q == S_IDLE) || (xfer && out_last_o));
  assign load        = in_valid_i && in_ready_o;

  if (MSB_FIRST) begin : g_msb
    assign out_data_o = sreg_q[W-1 -: LANES];
  end else begin : g_lsb
    assign out_data_o = sreg_q[LANES-1:0];
  end

  // Counter steps on every non-final beat and restarts on load, abort or word end.
  assign cnt_inc = xfer && !cnt_at_max;
  assign cnt_clr = clear_i || load || (xfer && cnt_at_max);

  beat_counter #(
    .MAX (BEATS - 1),
    .CW  (CW)
  ) u_beat_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc_i    (cnt_inc),
    .clr_i    (cnt_clr),
    .count_o  (beat_cnt),
    .at_max_o (cnt_at_max)
  );

  // Next state and shift register: abort, load, shift or hold on stall.
  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    if (clear_i) begin
      state_d = S_IDLE;
      sreg_d  = '0;
    end else if (load) begin
      state_d = S_SHIFT;
      sreg_d  = in_data_i;
    end else if (xfer) begin
      if (out_last_o) begin
        state_d = S_IDLE;
      end else if (MSB_FIRST) begin
        sreg_d = sreg_q << LANES;
      end else begin
        sreg_d = sreg_q >> LANES;
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sreg_q  <= '0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: three instances (2-lane MSB-first,
// 2-lane LSB-first, 8-lane) share one stimulus stream; a scoreboard per
// instance holds the beats each accepted word should produce.
module tb_piso_serializer;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } beat_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] in_data = 8'h00;

  logic       rdy [3];
  logic       vld [3];
  logic       lst [3];
  logic       bsy [3];
  logic [1:0] dm, dl;
  logic [7:0] dw;
  logic [7:0] od [3];

  beat_t q0[$], q1[$], q2[$];
  int total = 0;
  int bad = 0;
  logic [1:0] exp_b2b [8];

  assign od[0] = {6'b0, dm};
  assign od[1] = {6'b0, dl};
  assign od[2] = dw;

  always #5 clk = ~clk;

  piso_serializer #(.W(8), .LANES(2), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst_n(rst_n), .clear_i(clear), .in_valid_i(in_valid),
    .in_ready_o(rdy[0]), .in_data_i(in_data), .out_valid_o(vld[0]),
    .out_ready_i(out_ready), .out_data_o(dm), .out_last_o(lst[0]), .busy_o(bsy[0])
  );

  piso_serializer #(.W(8), .LANES(2), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .clear_i(clear), .in_valid_i(in_valid),
    .in_ready_o(rdy[1]), .in_data_i(in_data), .out_valid_o(vld[1]),
    .out_ready_i(out_ready), .out_data_o(dl), .out_last_o(lst[1]), .busy_o(bsy[1])
  );

  piso_serializer #(.W(8), .LANES(8), .MSB_FIRST(1'b1)) u_wide (
    .clk(clk), .rst_n(rst_n), .clear_i(clear), .in_valid_i(in_valid),
    .in_ready_o(rdy[2]), .in_data_i(in_data), .out_valid_o(vld[2]),
    .out_ready_i(out_ready), .out_data_o(dw), .out_last_o(lst[2]), .busy_o(bsy[2])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int sb_size(input int k);
    case (k)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic beat_t sb_pop(input int k);
    case (k)
      0:       return q0.pop_front();
      1:       return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  function automatic void sb_flush(input int k);
    case (k)
      0:       q0.delete();
      1:       q1.delete();
      default: q2.delete();
    endcase
  endfunction

  // Split a word into its expected beats in transmission order.
  function automatic void push_word(input int k, input logic [7:0] w);
    int   lanes;
    int   nb;
    bit   msb;
    logic [7:0] mask;
    beat_t b;
    lanes = (k == 2) ? 8 : 2;
    msb   = (k != 1);
    nb    = 8 / lanes;
    mask  = 8'((1 << lanes) - 1);
    for (int i = 0; i < nb; i++) begin
      if (msb) b.data = (w >> (8 - lanes * (i + 1))) & mask;
      else     b.data = (w >> (lanes * i)) & mask;
      b.last = (i == nb - 1);
      case (k)
        0:       q0.push_back(b);
        1:       q1.push_back(b);
        default: q2.push_back(b);
      endcase
    end
  endfunction

  // Score the handshakes of the current cycle, then advance one clock.
  task automatic step();
    beat_t e;
    for (int k = 0; k < 3; k++) begin
      if (!rst_n || clear) begin
        sb_flush(k);
      end else begin
        if (vld[k] && out_ready) begin
          total++;
          assert (sb_size(k) > 0) else begin
            bad++;
            $error("FAIL unexpected_beat%0d: observed %0h expected none", k, od[k]);
          end
          if (sb_size(k) > 0) begin
            e = sb_pop(k);
            chk($sformatf("beat_data%0d", k), {24'b0, od[k]}, {24'b0, e.data});
            chk($sformatf("beat_last%0d", k), {31'b0, lst[k]}, {31'b0, e.last});
          end
        end
        if (in_valid && rdy[k]) push_word(k, in_data);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    exp_b2b = '{2'b10, 2'b11, 2'b01, 2'b00, 2'b00, 2'b11, 2'b11, 2'b00};

    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_valid%0d", k), {31'b0, vld[k]}, 32'd0);
      chk($sformatf("rst_data%0d", k), {24'b0, od[k]}, 32'd0);
      chk($sformatf("rst_last%0d", k), {31'b0, lst[k]}, 32'd0);
      chk($sformatf("rst_busy%0d", k), {31'b0, bsy[k]}, 32'd0);
    end
    rst_n = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) chk($sformatf("rst_ready%0d", k), {31'b0, rdy[k]}, 32'd1);

    // Single word 0xB4, no backpressure.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'hB4;
    #1;
    step();
    in_valid = 1'b0;
    #1;
    chk("latency_valid", {31'b0, vld[0]}, 32'd1);
    for (int b = 0; b < 4; b++) begin
      #1;
      chk("t1_last", {31'b0, lst[0]}, {31'b0, b == 3});
      step();
    end
    #1;
    chk("t1_idle_busy", {31'b0, bsy[0]}, 32'd0);
    chk("t1_idle_ready", {31'b0, rdy[0]}, 32'd1);
    chk("t1_idle_valid", {31'b0, vld[1]}, 32'd0);

    // Backpressure while beat 2 of 0xB4 is presented.
    in_valid = 1'b1;
    in_data  = 8'hB4;
    #1;
    step();
    in_valid = 1'b0;
    #1;
    step();
    out_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      #1;
      chk("stall_msb_data", {30'b0, dm}, 32'h3);
      chk("stall_lsb_data", {30'b0, dl}, 32'h1);
      chk("stall_last", {31'b0, lst[0]}, 32'd0);
      chk("stall_valid", {31'b0, vld[0]}, 32'd1);
      chk("stall_ready", {31'b0, rdy[0]}, 32'd0);
      step();
    end
    out_ready = 1'b1;
    for (int s = 0; s < 3; s++) begin
      #1;
      step();
    end
    #1;
    chk("bp_done_valid", {31'b0, vld[0]}, 32'd0);

    // Back-to-back 0xB4 then 0x3C.
    in_valid = 1'b1;
    in_data  = 8'hB4;
    #1;
    step();
    in_data = 8'h3C;
    for (int b = 0; b < 8; b++) begin
      #1;
      chk("b2b_valid", {31'b0, vld[0]}, 32'd1);
      chk("b2b_data", {30'b0, dm}, {30'b0, exp_b2b[b]});
      chk("b2b_ready", {31'b0, rdy[0]}, {31'b0, (b % 4) == 3});
      step();
      if (b == 3) in_valid = 1'b0;
    end
    #1;
    chk("b2b_idle", {31'b0, vld[0]}, 32'd0);

    // Clear on beat 2 of 0xB4 while 0x3C is offered.
    in_valid = 1'b1;
    in_data  = 8'hB4;
    #1;
    step();
    in_valid = 1'b0;
    #1;
    step();
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h3C;
    #1;
    chk("clr_ready", {31'b0, rdy[0]}, 32'd0);
    step();
    clear = 1'b0;
    #1;
    chk("clr_valid_after", {31'b0, vld[0]}, 32'd0);
    chk("clr_busy_after", {31'b0, bsy[1]}, 32'd0);
    chk("clr_ready_after", {31'b0, rdy[0]}, 32'd1);
    step();
    in_valid = 1'b0;
    #1;
    chk("clr_first_beat", {30'b0, dm}, 32'h0);
    chk("clr_first_last", {31'b0, lst[0]}, 32'd0);
    for (int b = 0; b < 4; b++) begin
      #1;
      step();
    end

    // Single-beat configuration: 0xA5.
    in_valid = 1'b1;
    in_data  = 8'hA5;
    #1;
    step();
    in_valid = 1'b0;
    #1;
    chk("wide_valid", {31'b0, vld[2]}, 32'd1);
    chk("wide_data", {24'b0, dw}, 32'hA5);
    chk("wide_last", {31'b0, lst[2]}, 32'd1);
    step();
    #1;
    chk("wide_idle", {31'b0, vld[2]}, 32'd0);
    chk("wide_idle_last", {31'b0, lst[2]}, 32'd0);
    for (int b = 0; b < 3; b++) begin
      #1;
      step();
    end

    // Asynchronous reset in the middle of a word.
    in_valid = 1'b1;
    in_data  = 8'hB4;
    #1;
    step();
    in_valid = 1'b0;
    #1;
    step();
    #1;
    chk("mid_busy_pre", {31'b0, bsy[0]}, 32'd1);
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("mid_rst_valid%0d", k), {31'b0, vld[k]}, 32'd0);
      chk($sformatf("mid_rst_data%0d", k), {24'b0, od[k]}, 32'd0);
      chk($sformatf("mid_rst_last%0d", k), {31'b0, lst[k]}, 32'd0);
      chk($sformatf("mid_rst_busy%0d", k), {31'b0, bsy[k]}, 32'd0);
    end
    step();
    rst_n = 1'b1;
    #1;
    chk("mid_rst_ready", {31'b0, rdy[0]}, 32'd1);
    step();

    for (int k = 0; k < 3; k++) chk($sformatf("sb_drained%0d", k), sb_size(k), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
